debug_loader_unit: RTL and testbench
====================================

// Module: debug_loader_unit
// PURPOSE
//  Host-side control stage directly upstream of top_mips. Consumes command bytes from a UART
//  receiver, assembles 32-bit words and drives top_mips program-load port (i_write/i_address/i_instruction).
//  Gates top_mips i_enable for continuous or single-step execution; returns ack/PC bytes to the UART transmitter.
// PARAMETERS
//  NB_ADDR  32  width of instruction-memory address driven to top_mips (byte address)
//  NB_INST  32  instruction word width; fixed at 4 bytes
//  NB_BYTE  8   UART byte width
// PORTS
//  i_clk          in   1        system clock
//  i_reset        in   1        synchronous, active-high reset
//  i_rx_data      in   NB_BYTE  received byte, valid when i_rx_valid=1
//  i_rx_valid     in   1        one-cycle strobe per received byte
//  o_tx_data      out  NB_BYTE  byte to transmit
//  o_tx_valid     out  1        o_tx_data valid; held until accepted
//  i_tx_ready     in   1        transmitter accepts byte when o_tx_valid & i_tx_ready
//  i_halt         in   1        core reached HALT (level)
//  i_pc           in   NB_ADDR  current core PC
//  o_write        out  1        one-cycle instruction-memory write strobe
//  o_address      out  NB_ADDR  write address
//  o_instruction  out  NB_INST  write data
//  o_enable       out  1        core clock-enable
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; word/byte counters 0; i_reset wins over every event, incl. mid-load/mid-run.
//  FSM: IDLE, LOAD_CNT, LOAD_BYTE, LOAD_WR, RUN, STEP, SEND_PC, SEND_ACK.
//  IDLE: on i_rx_valid decode: 0x4C 'L' -> LOAD_CNT; 0x43 'C' -> RUN; 0x53 'S' -> STEP; other bytes dropped.
//  LOAD_CNT: next byte = N instructions. N=0 -> SEND_ACK directly; else word index=0, byte count=0 -> LOAD_BYTE.
//  LOAD_BYTE: each byte shifted in MSB-first; on 4th byte -> LOAD_WR.
//  LOAD_WR (1 cycle): o_write=1, o_instruction=assembled word, o_address=index*4 (index 0..N-1);
//   o_write rises the cycle after the 4th byte strobe. Last word -> SEND_ACK, else -> LOAD_BYTE.
//  RUN: o_enable=1 from the cycle after 'C' is accepted. On a cycle with i_halt=1: o_enable=0 next cycle,
//   i_pc latched that cycle -> SEND_PC. i_halt already 1 on entry: o_enable high exactly 1 cycle.
//  STEP: o_enable=1 for exactly one cycle (cycle after 'S'); next cycle latch i_pc -> SEND_PC.
//  SEND_PC: 4 bytes of latched PC, MSB first; SEND_ACK: single byte 0x4B 'K'. Both -> IDLE after last byte.
//  TX handshake: o_tx_valid/o_tx_data stable until cycle with i_tx_ready=1; next byte earliest cycle after.
//   i_tx_ready with o_tx_valid=0 is ignored.
//  RX bytes arriving in RUN/STEP/SEND_PC/SEND_ACK/LOAD_WR: dropped, never queued.
//  Sender must not send a byte in LOAD_WR; a byte there is lost and load stalls until reset.
//  o_address/o_instruction hold last written values when o_write=0.
//  o_write and o_enable never high in the same cycle.
//  Index counter 8 bits, so N<=255; address wraps never (max 0x3F8).
// TESTING
//  1) Reset, send 4C 02 00 22 20 20 12 34 56 78 -> o_write at addr 0 data 0x00222020, addr 4 data 0x12345678;
//     then tx 0x4B.
//  2) Send 4C 00 -> no o_write; tx 0x4B within 2 cycles of ready.
//  3) Send 53 with i_pc=0x00000004 -> o_enable high 1 cycle; tx 00 00 00 04.
//  4) Send 43, raise i_halt 5 cycles later with i_pc=0x18 -> o_enable low next cycle; tx 00 00 00 18.
//  5) i_tx_ready held 0 for 10 cycles during SEND_PC -> o_tx_data/o_tx_valid unchanged; no byte skipped.
//  6) Reset asserted after 2 load bytes; then 4C 01 AA BB CC DD -> single write addr 0 data 0xAABBCCDD;
//     bytes 0x7F in IDLE ignored.

Source files
------------

// File: rtl/debug_loader_unit_if.sv
// Purpose: bundles the UART byte streams, core status and program-load/enable
// signals that connect the debug loader to its host side and to top_mips.
//   i_rx_data/i_rx_valid   received UART byte and its one-cycle strobe
//   o_tx_data/o_tx_valid   byte to transmit, held until i_tx_ready
//   i_tx_ready             transmitter accepts o_tx_data
//   i_halt/i_pc            core halt level and current PC
//   o_write/o_address/o_instruction  instruction-memory write port
//   o_enable               core clock-enable
// Modports: slave = loader side, master = environment side.
interface debug_loader_unit_if #(
  parameter int unsigned NB_ADDR = 32,
  parameter int unsigned NB_INST = 32,
  parameter int unsigned NB_BYTE = 8
);
  logic [NB_BYTE-1:0] i_rx_data;
  logic               i_rx_valid;
  logic [NB_BYTE-1:0] o_tx_data;
  logic               o_tx_valid;
  logic               i_tx_ready;
  logic               i_halt;
  logic [NB_ADDR-1:0] i_pc;
  logic               o_write;
  logic [NB_ADDR-1:0] o_address;
  logic [NB_INST-1:0] o_instruction;
  logic               o_enable;

  modport slave (
    input  i_rx_data, i_rx_valid, i_tx_ready, i_halt, i_pc,
    output o_tx_data, o_tx_valid, o_write, o_address, o_instruction, o_enable
  );

  modport master (
    output i_rx_data, i_rx_valid, i_tx_ready, i_halt, i_pc,
    input  o_tx_data, o_tx_valid, o_write, o_address, o_instruction, o_enable
  );
endinterface

// File: rtl/debug_loader_unit.sv
// Purpose: host-side control stage ahead of top_mips. Decodes UART command
// bytes, loads N big-endian instruction words into instruction memory, gates
// the core enable for run/single-step, and returns 'K' acks or the halted PC.
// Ports:
//   i_clk    system clock
//   i_reset  synchronous active-high reset
//   bus      debug_loader_unit_if.slave (UART rx/tx, halt/pc, load port, enable)
module debug_loader_unit #(
  parameter int unsigned NB_ADDR = 32,
  parameter int unsigned NB_INST = 32,
  parameter int unsigned NB_BYTE = 8
) (
  input logic               i_clk,
  input logic               i_reset,
  debug_loader_unit_if.slave bus
);

  localparam int unsigned NB_SHIFT = NB_INST - NB_BYTE;
  localparam int unsigned NB_IDX   = 8;

  localparam logic [NB_BYTE-1:0] CMD_LOAD = NB_BYTE'(8'h4C);
  localparam logic [NB_BYTE-1:0] CMD_CONT = NB_BYTE'(8'h43);
  localparam logic [NB_BYTE-1:0] CMD_STEP = NB_BYTE'(8'h53);
  localparam logic [NB_BYTE-1:0] CMD_ACK  = NB_BYTE'(8'h4B);

  typedef enum logic [2:0] {
    IDLE, LOAD_CNT, LOAD_BYTE, LOAD_WR, RUN, STEP, SEND_PC, SEND_ACK
  } state_t;

  state_t state_q, state_nx;

  logic [1:0]          byte_cnt_q, byte_cnt_nx;
  logic [NB_IDX-1:0]   word_idx_q, word_idx_nx;
  logic [NB_IDX-1:0]   word_cnt_q, word_cnt_nx;
  logic [NB_SHIFT-1:0] shift_q, shift_nx;
  logic [NB_ADDR-1:0]  pc_q, pc_nx;
  logic                step_phase_q, step_phase_nx;
  logic                write_q, write_nx;
  logic [NB_ADDR-1:0]  address_q, address_nx;
  logic [NB_INST-1:0]  instruction_q, instruction_nx;
  logic                enable_q, enable_nx;
  logic                tx_valid_q, tx_valid_nx;
  logic [NB_BYTE-1:0]  tx_data_q, tx_data_nx;

  logic tx_accept;
  logic last_word;

  assign tx_accept = tx_valid_q & bus.i_tx_ready;
  assign last_word = (NB_IDX'(word_idx_q + NB_IDX'(1)) == word_cnt_q);

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) state_q <= IDLE;
    else         state_q <= state_nx;
  end

  // Next-state decode
  always_comb begin
    state_nx = state_q;
    case (state_q)
      IDLE: begin
        if (bus.i_rx_valid) begin
          if (bus.i_rx_data == CMD_LOAD)      state_nx = LOAD_CNT;
          else if (bus.i_rx_data == CMD_CONT) state_nx = RUN;
          else if (bus.i_rx_data == CMD_STEP) state_nx = STEP;
        end
      end
      LOAD_CNT: begin
        if (bus.i_rx_valid) state_nx = (bus.i_rx_data == '0) ? SEND_ACK : LOAD_BYTE;
      end
      LOAD_BYTE: begin
        if (bus.i_rx_valid && byte_cnt_q == 2'd3) state_nx = LOAD_WR;
      end
      LOAD_WR:  state_nx = last_word ? SEND_ACK : LOAD_BYTE;
      RUN:      if (bus.i_halt) state_nx = SEND_PC;
      STEP:     if (step_phase_q) state_nx = SEND_PC;
      SEND_PC:  if (tx_accept && byte_cnt_q == 2'd3) state_nx = IDLE;
      SEND_ACK: if (tx_accept) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // Next values of datapath and registered outputs
  always_comb begin
    byte_cnt_nx    = byte_cnt_q;
    word_idx_nx    = word_idx_q;
    word_cnt_nx    = word_cnt_q;
    shift_nx       = shift_q;
    pc_nx          = pc_q;
    step_phase_nx  = step_phase_q;
    address_nx     = address_q;
    instruction_nx = instruction_q;
    tx_valid_nx    = tx_valid_q;
    tx_data_nx     = tx_data_q;
    write_nx       = 1'b0;
    enable_nx      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.i_rx_valid) begin
          if (bus.i_rx_data == CMD_CONT) begin
            enable_nx = 1'b1;
          end else if (bus.i_rx_data == CMD_STEP) begin
            enable_nx     = 1'b1;
            step_phase_nx = 1'b0;
          end
        end
      end
      LOAD_CNT: begin
        if (bus.i_rx_valid) begin
          word_cnt_nx = NB_IDX'(bus.i_rx_data);
          word_idx_nx = '0;
          byte_cnt_nx = '0;
          if (bus.i_rx_data == '0) begin
            tx_valid_nx = 1'b1;
            tx_data_nx  = CMD_ACK;
          end
        end
      end
      LOAD_BYTE: begin
        // The 4th byte bypasses the shifter straight into the write word.
        if (bus.i_rx_valid) begin
          shift_nx    = {shift_q[NB_SHIFT-NB_BYTE-1:0], bus.i_rx_data};
          byte_cnt_nx = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            write_nx       = 1'b1;
            instruction_nx = {shift_q, bus.i_rx_data};
            address_nx     = NB_ADDR'({word_idx_q, 2'b00});
          end
        end
      end
      LOAD_WR: begin
        word_idx_nx = word_idx_q + NB_IDX'(1);
        if (last_word) begin
          tx_valid_nx = 1'b1;
          tx_data_nx  = CMD_ACK;
        end
      end
      RUN: begin
        if (bus.i_halt) begin
          pc_nx       = bus.i_pc;
          tx_valid_nx = 1'b1;
          tx_data_nx  = bus.i_pc[NB_ADDR-1 -: NB_BYTE];
          byte_cnt_nx = '0;
        end else begin
          enable_nx = 1'b1;
        end
      end
      STEP: begin
        // Phase 0 is the enabled cycle; PC is sampled once the core has advanced.
        if (!step_phase_q) begin
          step_phase_nx = 1'b1;
        end else begin
          step_phase_nx = 1'b0;
          pc_nx         = bus.i_pc;
          tx_valid_nx   = 1'b1;
          tx_data_nx    = bus.i_pc[NB_ADDR-1 -: NB_BYTE];
          byte_cnt_nx   = '0;
        end
      end
      SEND_PC: begin
        // pc_q shifts left so the next byte to send is always just below the top.
        if (tx_accept) begin
          if (byte_cnt_q == 2'd3) begin
            tx_valid_nx = 1'b0;
            byte_cnt_nx = '0;
          end else begin
            tx_data_nx  = pc_q[NB_ADDR-NB_BYTE-1 -: NB_BYTE];
            pc_nx       = pc_q << NB_BYTE;
            byte_cnt_nx = byte_cnt_q + 2'd1;
          end
        end
      end
      SEND_ACK: begin
        if (tx_accept) tx_valid_nx = 1'b0;
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      byte_cnt_q    <= '0;
      word_idx_q    <= '0;
      word_cnt_q    <= '0;
      shift_q       <= '0;
      pc_q          <= '0;
      step_phase_q  <= 1'b0;
      write_q       <= 1'b0;
      address_q     <= '0;
      instruction_q <= '0;
      enable_q      <= 1'b0;
      tx_valid_q    <= 1'b0;
      tx_data_q     <= '0;
    end else begin
      byte_cnt_q    <= byte_cnt_nx;
      word_idx_q    <= word_idx_nx;
      word_cnt_q    <= word_cnt_nx;
      shift_q       <= shift_nx;
      pc_q          <= pc_nx;
      step_phase_q  <= step_phase_nx;
      write_q       <= write_nx;
      address_q     <= address_nx;
      instruction_q <= instruction_nx;
      enable_q      <= enable_nx;
      tx_valid_q    <= tx_valid_nx;
      tx_data_q     <= tx_data_nx;
    end
  end

  assign bus.o_write       = write_q;
  assign bus.o_address     = address_q;
  assign bus.o_instruction = instruction_q;
  assign bus.o_enable      = enable_q;
  assign bus.o_tx_valid    = tx_valid_q;
  assign bus.o_tx_data     = tx_data_q;

endmodule

// File: tb/tb_debug_loader_unit.sv
// Purpose: self-checking bench for debug_loader_unit. A transaction-level
// model predicts memory writes, transmitted bytes and enable-cycle counts for
// each host command; a monitor records what the DUT actually did.
module tb_debug_loader_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  debug_loader_unit_if bus ();

  debug_loader_unit dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [7:0]  tx_q[$];
  int          enable_cycles = 0;

  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  logic [7:0]  exp_tx[$];
  logic [31:0] load_words[$];

  bit ready_hold   = 1'b0;
  bit ready_always = 1'b0;

  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (bus.o_write) begin
        wr_addr_q.push_back(bus.o_address);
        wr_data_q.push_back(bus.o_instruction);
      end
      if (bus.o_enable) enable_cycles++;
      if (bus.o_write || bus.o_enable)
        check("write_enable_exclusive", 32'(bus.o_write & bus.o_enable), 32'd0);
      if (prev_stall) begin
        check("tx_valid_hold", 32'(bus.o_tx_valid), 32'd1);
        check("tx_data_hold", 32'(bus.o_tx_data), 32'(prev_data));
      end
      if (bus.o_tx_valid && bus.i_tx_ready) tx_q.push_back(bus.o_tx_data);
      prev_stall = bus.o_tx_valid && !bus.i_tx_ready;
      prev_data  = bus.o_tx_data;
    end
  end

  // Transmitter-ready driver: random unless forced.
  initial begin
    bus.i_tx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (ready_hold)        bus.i_tx_ready = 1'b0;
      else if (ready_always) bus.i_tx_ready = 1'b1;
      else                   bus.i_tx_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bus.i_rx_data  = b;
    bus.i_rx_valid = 1'b1;
    tick(1);
    bus.i_rx_valid = 1'b0;
    tick(gap);
  endtask

  task automatic wait_tx(input int n, input int budget);
    int c = 0;
    while (tx_q.size() < n && c < budget) begin
      tick(1);
      c++;
    end
    check("tx_arrival", 32'(tx_q.size() >= n), 32'd1);
  endtask

  task automatic compare_writes(input string tag);
    check({tag, "_wr_count"}, 32'(wr_addr_q.size()), 32'(exp_addr.size()));
    while (wr_addr_q.size() > 0 && exp_addr.size() > 0) begin
      check({tag, "_wr_addr"}, wr_addr_q.pop_front(), exp_addr.pop_front());
      check({tag, "_wr_data"}, wr_data_q.pop_front(), exp_data.pop_front());
    end
    wr_addr_q.delete(); wr_data_q.delete();
    exp_addr.delete();  exp_data.delete();
  endtask

  task automatic compare_tx(input string tag);
    check({tag, "_tx_count"}, 32'(tx_q.size()), 32'(exp_tx.size()));
    while (tx_q.size() > 0 && exp_tx.size() > 0)
      check({tag, "_tx_byte"}, 32'(tx_q.pop_front()), 32'(exp_tx.pop_front()));
    tx_q.delete();
    exp_tx.delete();
  endtask

  // Model: N words land at byte addresses 0,4,8..., then one 'K' is returned.
  task automatic do_load();
    logic [31:0] w;
    send_byte(8'h4C, int'($urandom_range(0, 1)));
    send_byte(8'(load_words.size()), int'($urandom_range(0, 1)));
    for (int i = 0; i < load_words.size(); i++) begin
      w = load_words[i];
      for (int b = 0; b < 4; b++)
        send_byte(8'(w >> (24 - 8 * b)),
                  (b == 3) ? 1 + int'($urandom_range(0, 1)) : int'($urandom_range(0, 1)));
      exp_addr.push_back(32'(i * 4));
      exp_data.push_back(w);
    end
    exp_tx.push_back(8'h4B);
  endtask

  task automatic expect_pc(input logic [31:0] pc);
    for (int b = 0; b < 4; b++) exp_tx.push_back(8'(pc >> (24 - 8 * b)));
  endtask

  // Model: single step enables the core for exactly one cycle, then reports PC.
  task automatic do_step(input string tag, input logic [31:0] pc);
    int en0;
    bus.i_pc = pc;
    en0 = enable_cycles;
    send_byte(8'h53, 0);
    expect_pc(pc);
    wait_tx(4, 400);
    tick(2);
    check({tag, "_enable_cycles"}, 32'(enable_cycles - en0), 32'd1);
    compare_tx(tag);
  endtask

  // Model: run keeps enable high through the first cycle halt is seen.
  task automatic do_run(input string tag, input logic [31:0] pc, input int d);
    int en0;
    bus.i_pc = pc;
    en0 = enable_cycles;
    send_byte(8'h43, 0);
    tick(d);
    bus.i_halt = 1'b1;
    tick(1);
    check({tag, "_enable_drop"}, 32'(bus.o_enable), 32'd0);
    expect_pc(pc);
    wait_tx(4, 400);
    bus.i_halt = 1'b0;
    tick(2);
    check({tag, "_enable_cycles"}, 32'(enable_cycles - en0), 32'(d + 1));
    compare_tx(tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_write"},       32'(bus.o_write), 32'd0);
    check({tag, "_enable"},      32'(bus.o_enable), 32'd0);
    check({tag, "_tx_valid"},    32'(bus.o_tx_valid), 32'd0);
    check({tag, "_tx_data"},     32'(bus.o_tx_data), 32'd0);
    check({tag, "_address"},     bus.o_address, 32'd0);
    check({tag, "_instruction"}, bus.o_instruction, 32'd0);
  endtask

  initial begin
    logic [7:0]  junk;
    logic [31:0] pc;
    int          en0;
    int          op;

    rst            = 1'b1;
    bus.i_rx_valid = 1'b0;
    bus.i_rx_data  = '0;
    bus.i_halt     = 1'b0;
    bus.i_pc       = '0;
    tick(3);
    check_reset_outputs("reset");
    rst = 1'b0;
    tick(2);

    // Two-word load.
    load_words = '{32'h00222020, 32'h12345678};
    do_load();
    wait_tx(1, 400);
    tick(2);
    compare_writes("load2");
    compare_tx("load2");

    // Zero-length load: ack only, promptly.
    ready_always = 1'b1;
    tick(2);
    load_words.delete();
    send_byte(8'h4C, 0);
    send_byte(8'h00, 0);
    exp_tx.push_back(8'h4B);
    wait_tx(1, 2);
    tick(2);
    compare_writes("load0");
    compare_tx("load0");
    ready_always = 1'b0;

    do_step("step", 32'h00000004);
    do_run("run", 32'h00000018, 5);

    // Transmitter stalls for 10 cycles in the middle of PC return.
    ready_hold = 1'b1;
    tick(1);
    pc = $urandom;
    bus.i_pc = pc;
    en0 = enable_cycles;
    send_byte(8'h53, 0);
    tick(12);
    check("stall_no_bytes", 32'(tx_q.size()), 32'd0);
    check("stall_tx_valid", 32'(bus.o_tx_valid), 32'd1);
    check("stall_tx_data", 32'(bus.o_tx_data), 32'(pc[31:24]));
    ready_hold = 1'b0;
    expect_pc(pc);
    wait_tx(4, 400);
    tick(2);
    check("stall_enable_cycles", 32'(enable_cycles - en0), 32'd1);
    compare_tx("stall");

    // Reset in the middle of a load abandons it.
    send_byte(8'h4C, 0);
    send_byte(8'h02, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    rst = 1'b1;
    tick(2);
    check_reset_outputs("midload_reset");
    rst = 1'b0;
    tick(1);
    send_byte(8'h7F, 3);
    compare_writes("junk7f");
    compare_tx("junk7f");
    load_words = '{32'hAABBCCDD};
    do_load();
    wait_tx(1, 400);
    tick(2);
    compare_writes("after_reset");
    compare_tx("after_reset");

    // Randomised command mix.
    for (int it = 0; it < 16; it++) begin
      op = int'($urandom_range(0, 3));
      case (op)
        0: begin
          load_words.delete();
          for (int k = 0; k < int'($urandom_range(1, 5)); k++) load_words.push_back($urandom);
          do_load();
          wait_tx(1, 800);
          tick(2);
          compare_writes("rnd_load");
          compare_tx("rnd_load");
        end
        1: do_step("rnd_step", $urandom);
        2: do_run("rnd_run", $urandom, int'($urandom_range(0, 7)));
        default: begin
          do junk = 8'($urandom);
          while (junk == 8'h4C || junk == 8'h43 || junk == 8'h53);
          en0 = enable_cycles;
          send_byte(junk, 4);
          check("rnd_junk_enable", 32'(enable_cycles - en0), 32'd0);
          compare_writes("rnd_junk");
          compare_tx("rnd_junk");
        end
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
